// File: rtl/uart_cfg_core_if.sv
// Host-side and serial-pin bundle for uart_cfg_core.
// master: host plus far-end rx driver; slave: the core.
interface uart_cfg_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] dintx;
   logic                 newd;
   logic                 tx;
   logic                 busytx;
   logic                 donetx;
   logic                 rx;
   logic [DATA_BITS-1:0] doutrx;
   logic                 donerx;
   logic                 perr;
   logic                 ferr;

   modport master (
      output dintx, newd, rx,
      input  tx, busytx, donetx,
      input  doutrx, donerx, perr, ferr
   );

   modport slave (
      input  dintx, newd, rx,
      output tx, busytx, donetx,
      output doutrx, donerx, perr, ferr
   );
endinterface

// File: rtl/uart_cfg_core.sv
// Parametrised full-duplex UART: configurable width, parity, stop bits.
// Shared free-running oversample tick; TX and RX FSMs are independent.
module uart_cfg_core #(
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input logic            clk,
   input logic            rst,
   uart_cfg_core_if.slave bus
);
   localparam int DIV_Q = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV   = (DIV_Q < 1) ? 1 : DIV_Q;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW    = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);
   localparam logic          PEN      = 1'(PARITY_EN);
   localparam logic          PODD     = 1'(PARITY_ODD);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BREAK = 3'd5;

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   logic [2:0]           tx_st;
   logic [OW-1:0]        tx_os;
   logic [3:0]           tx_bit;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par;
   logic                 tx_end;

   assign tx_end = tick && (tx_os == OS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st      <= S_IDLE;
         tx_os      <= '0;
         tx_bit     <= '0;
         tx_sh      <= '0;
         tx_par     <= 1'b0;
         bus.tx     <= 1'b1;
         bus.busytx <= 1'b0;
         bus.donetx <= 1'b0;
      end else begin
         bus.donetx <= 1'b0;
         if (tx_st == S_IDLE) tx_os <= '0;
         else if (tx_end)     tx_os <= '0;
         else if (tick)       tx_os <= tx_os + 1'b1;
         unique case (tx_st)
            S_IDLE: if (bus.newd) begin
               tx_st      <= S_START;
               tx_sh      <= bus.dintx;
               tx_par     <= (^bus.dintx) ^ PODD;
               tx_bit     <= '0;
               bus.tx     <= 1'b0;
               bus.busytx <= 1'b1;
            end
            S_START: if (tx_end) begin
               tx_st  <= S_DATA;
               bus.tx <= tx_sh[0];
            end
            S_DATA: if (tx_end) begin
               if (tx_bit == DB_LAST) begin
                  tx_bit <= '0;
                  tx_st  <= PEN ? S_PAR : S_STOP;
                  bus.tx <= PEN ? tx_par : 1'b1;
               end else begin
                  tx_bit <= tx_bit + 1'b1;
                  tx_sh  <= tx_sh >> 1;
                  bus.tx <= tx_sh[1];
               end
            end
            S_PAR: if (tx_end) begin
               tx_st  <= S_STOP;
               bus.tx <= 1'b1;
            end
            S_STOP: if (tx_end) begin
               if (tx_bit == SB_LAST) begin
                  tx_st      <= S_IDLE;
                  tx_bit     <= '0;
                  bus.busytx <= 1'b0;
                  bus.donetx <= 1'b1;
               end else begin
                  tx_bit <= tx_bit + 1'b1;
               end
            end
            default: tx_st <= S_IDLE;
         endcase
      end
   end

   logic [1:0]           rx_sync;
   logic                 rxs;
   logic [2:0]           rx_st;
   logic [OW-1:0]        rx_os;
   logic [3:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_par;
   logic                 rx_mid;

   assign rxs = rx_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_sync <= 2'b11;
      else     rx_sync <= {rx_sync[0], bus.rx};
   end

   // START waits half a bit; every later sample is one full bit on.
   assign rx_mid = tick &&
      (rx_os == ((rx_st == S_START) ? OS_HALF : OS_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_st      <= S_IDLE;
         rx_os      <= '0;
         rx_bit     <= '0;
         rx_sh      <= '0;
         rx_par     <= 1'b0;
         bus.doutrx <= '0;
         bus.donerx <= 1'b0;
         bus.perr   <= 1'b0;
         bus.ferr   <= 1'b0;
      end else begin
         bus.donerx <= 1'b0;
         if (rx_st == S_IDLE || rx_st == S_BREAK) rx_os <= '0;
         else if (rx_mid) rx_os <= '0;
         else if (tick)   rx_os <= rx_os + 1'b1;
         unique case (rx_st)
            S_IDLE: if (!rxs) begin
               rx_st  <= S_START;
               rx_bit <= '0;
            end
            S_START: if (rx_mid) rx_st <= rxs ? S_IDLE : S_DATA;
            S_DATA: if (rx_mid) begin
               rx_sh <= {rxs, rx_sh[DATA_BITS-1:1]};
               if (rx_bit == DB_LAST) begin
                  rx_bit <= '0;
                  rx_st  <= PEN ? S_PAR : S_STOP;
               end else begin
                  rx_bit <= rx_bit + 1'b1;
               end
            end
            S_PAR: if (rx_mid) begin
               rx_par <= rxs;
               rx_st  <= S_STOP;
            end
            S_STOP: if (rx_mid) begin
               bus.donerx <= 1'b1;
               bus.doutrx <= rx_sh;
               bus.perr   <= PEN && (rx_par != ((^rx_sh) ^ PODD));
               bus.ferr   <= !rxs;
               // all-zero data with a low stop bit is a line break
               rx_st <= (!rxs && rx_sh == '0) ? S_BREAK : S_IDLE;
            end
            S_BREAK: if (rxs) rx_st <= S_IDLE;
            default: rx_st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_cfg_core.sv
// Scoreboard bench for uart_cfg_core: 8N1 and 7O2 instances,
// loopback or bench-driven rx, 32 clk per bit.
module tb_uart_cfg_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_cfg_core_if #(.DATA_BITS(8)) ia ();
   uart_cfg_core_if #(.DATA_BITS(7)) ib ();

   logic lb_a  = 1'b1;
   logic lb_b  = 1'b1;
   logic rxa_d = 1'b1;
   logic rxb_d = 1'b1;

   assign ia.rx = lb_a ? ia.tx : rxa_d;
   assign ib.rx = lb_b ? ib.tx : rxb_d;

   uart_cfg_core #(
      .CLK_FREQ(3200000), .BAUD_RATE(100000), .DATA_BITS(8),
      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(16)
   ) u_a (
      .clk(clk), .rst(rst), .bus(ia.slave)
   );

   uart_cfg_core #(
      .CLK_FREQ(3200000), .BAUD_RATE(100000), .DATA_BITS(7),
      .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .OVERSAMPLE(16)
   ) u_b (
      .clk(clk), .rst(rst), .bus(ib.slave)
   );

   typedef struct {
      logic [8:0] d;
      logic       p;
      logic       f;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int dtx_a = 0, dtx_b = 0, drx_a = 0, drx_b = 0;
   int dtx_a_cyc = 0, dtx_b_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [8:0] d, input logic p,
                               input logic f);
      exp_t e;
      e.d = d;
      e.p = p;
      e.f = f;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ia.donetx) begin
            dtx_a++;
            dtx_a_cyc = cyc;
            chk("a_busy_at_done", 32'(ia.busytx), 0);
         end
         if (ib.donetx) begin
            dtx_b++;
            dtx_b_cyc = cyc;
            chk("b_busy_at_done", 32'(ib.busytx), 0);
         end
         if (ia.donerx) begin
            drx_a++;
            if (qa.size() == 0) chk("a_rx_extra", 32'(ia.donerx), 0);
            else begin
               e = qa.pop_front();
               chk("a_rx_data", 32'(ia.doutrx), 32'(e.d));
               chk("a_rx_perr", 32'(ia.perr), 32'(e.p));
               chk("a_rx_ferr", 32'(ia.ferr), 32'(e.f));
            end
         end
         if (ib.donerx) begin
            drx_b++;
            if (qb.size() == 0) chk("b_rx_extra", 32'(ib.donerx), 0);
            else begin
               e = qb.pop_front();
               chk("b_rx_data", 32'(ib.doutrx), 32'(e.d));
               chk("b_rx_perr", 32'(ib.perr), 32'(e.p));
               chk("b_rx_ferr", 32'(ib.ferr), 32'(e.f));
            end
         end
      end
   end

   task automatic start_tx(input bit sel, input logic [8:0] d,
                           output int t0);
      @(negedge clk);
      if (sel) begin
         ib.dintx = d[6:0];
         ib.newd  = 1'b1;
      end else begin
         ia.dintx = d[7:0];
         ia.newd  = 1'b1;
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      ia.newd = 1'b0;
      ib.newd = 1'b0;
   endtask

   task automatic send_chk(input bit sel, input logic [8:0] d,
                           input logic [15:0] bits, input int nb,
                           input int lo);
      int t0, base, lat, n;
      base = sel ? dtx_b : dtx_a;
      start_tx(sel, d, t0);
      chk(sel ? "b_busy_start" : "a_busy_start",
          32'(sel ? ib.busytx : ia.busytx), 1);
      repeat (16) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         chk(sel ? "b_tx_bit" : "a_tx_bit",
             32'(sel ? ib.tx : ia.tx), 32'(bits[k]));
         if (k < nb - 1) repeat (32) @(negedge clk);
      end
      n = 0;
      while ((sel ? dtx_b : dtx_a) == base && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk(sel ? "b_done_count" : "a_done_count",
          32'((sel ? dtx_b : dtx_a) - base), 1);
      lat = (sel ? dtx_b_cyc : dtx_a_cyc) - t0;
      // free-running tick puts the first bit edge one clock either way
      chk(sel ? "b_tx_lat_ok" : "a_tx_lat_ok",
          32'(lat >= lo && lat <= lo + 1), 1);
   endtask

   task automatic drive_rx(input bit sel, input logic [15:0] bits,
                           input int nb, input int last_len);
      for (int k = 0; k < nb; k++) begin
         if (sel) rxb_d = bits[k];
         else     rxa_d = bits[k];
         repeat ((k == nb - 1) ? last_len : 32) @(negedge clk);
      end
   endtask

   task automatic wait_rx(input bit sel, input int budget);
      int n;
      n = 0;
      while ((sel ? qb.size() : qa.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(sel ? "b_rx_pending" : "a_rx_pending",
          32'(sel ? qb.size() : qa.size()), 0);
      if (sel) qb.delete();
      else     qa.delete();
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int t0, base, base_b, brx_a, brx_b, n;
      ia.dintx = '0;
      ia.newd  = 1'b0;
      ib.dintx = '0;
      ib.newd  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(ia.tx), 1);
      chk("rst_busytx", 32'(ia.busytx), 0);
      chk("rst_donetx", 32'(ia.donetx), 0);
      chk("rst_doutrx", 32'(ia.doutrx), 0);
      chk("rst_donerx", 32'(ia.donerx), 0);
      chk("rst_perr", 32'(ia.perr), 0);
      chk("rst_ferr", 32'(ia.ferr), 0);
      chk("rst_b_tx", 32'(ib.tx), 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      qa.push_back(mk(9'hA5, 1'b0, 1'b0));
      send_chk(1'b0, 9'hA5, {7'd0, 1'b1, 8'hA5, 1'b0}, 10, 319);
      wait_rx(1'b0, 400);

      qb.push_back(mk(9'h55, 1'b0, 1'b0));
      send_chk(1'b1, 9'h55, {5'd0, 2'b11, 1'b1, 7'h55, 1'b0}, 11, 351);
      wait_rx(1'b1, 400);

      lb_b = 1'b0;
      qb.push_back(mk(9'h55, 1'b1, 1'b0));
      drive_rx(1'b1, {5'd0, 2'b11, 1'b0, 7'h55, 1'b0}, 11, 32);
      wait_rx(1'b1, 100);

      lb_a = 1'b0;
      qa.push_back(mk(9'h3C, 1'b0, 1'b1));
      drive_rx(1'b0, {7'd0, 1'b0, 8'h3C, 1'b0}, 10, 24);
      rxa_d = 1'b1;
      wait_rx(1'b0, 100);
      repeat (64) @(negedge clk);

      brx_a = drx_a;
      rxa_d = 1'b0;
      repeat (8) @(negedge clk);
      rxa_d = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_no_rx", 32'(drx_a - brx_a), 0);
      chk("glitch_dout", 32'(ia.doutrx), 32'h3C);
      chk("glitch_ferr", 32'(ia.ferr), 1);

      brx_a = drx_a;
      qa.push_back(mk(9'h000, 1'b0, 1'b1));
      rxa_d = 1'b0;
      repeat (640) @(negedge clk);
      chk("brk_rx_count", 32'(drx_a - brx_a), 1);
      chk("brk_ferr_hold", 32'(ia.ferr), 1);
      rxa_d = 1'b1;
      repeat (64) @(negedge clk);
      chk("brk_release_rx", 32'(drx_a - brx_a), 1);
      qa.push_back(mk(9'h81, 1'b0, 1'b0));
      drive_rx(1'b0, {7'd0, 1'b1, 8'h81, 1'b0}, 10, 32);
      wait_rx(1'b0, 100);

      lb_a = 1'b1;
      base = dtx_a;
      qa.push_back(mk(9'h5A, 1'b0, 1'b0));
      start_tx(1'b0, 9'h5A, t0);
      repeat (100) @(negedge clk);
      ia.dintx = 8'hFF;
      ia.newd  = 1'b1;
      @(negedge clk);
      ia.newd  = 1'b0;
      repeat (700) @(negedge clk);
      chk("ignore_newd_done", 32'(dtx_a - base), 1);
      chk("ignore_newd_idle", 32'(ia.busytx), 0);
      wait_rx(1'b0, 10);

      base = dtx_a;
      qa.push_back(mk(9'h11, 1'b0, 1'b0));
      qa.push_back(mk(9'h22, 1'b0, 1'b0));
      @(negedge clk);
      ia.dintx = 8'h11;
      ia.newd  = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ia.donetx && n < 500);
      ia.dintx = 8'h22;
      chk("b2b_gap_busy", 32'(ia.busytx), 0);
      @(negedge clk);
      chk("b2b_restart_busy", 32'(ia.busytx), 1);
      chk("b2b_restart_tx", 32'(ia.tx), 0);
      ia.newd = 1'b0;
      repeat (400) @(negedge clk);
      chk("b2b_done_count", 32'(dtx_a - base), 2);
      wait_rx(1'b0, 10);

      base   = dtx_a;
      base_b = dtx_b;
      brx_a  = drx_a;
      brx_b  = drx_b;
      start_tx(1'b0, 9'hC3, t0);
      start_tx(1'b1, 9'h2A, t0);
      repeat (100) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tx", 32'(ia.tx), 1);
      chk("arst_busytx", 32'(ia.busytx), 0);
      chk("arst_donetx", 32'(ia.donetx), 0);
      chk("arst_doutrx", 32'(ia.doutrx), 0);
      chk("arst_donerx", 32'(ia.donerx), 0);
      chk("arst_perr", 32'(ia.perr), 0);
      chk("arst_ferr", 32'(ia.ferr), 0);
      chk("arst_b_tx", 32'(ib.tx), 1);
      chk("arst_b_busytx", 32'(ib.busytx), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (500) @(negedge clk);
      chk("arst_no_donetx_a", 32'(dtx_a - base), 0);
      chk("arst_no_donetx_b", 32'(dtx_b - base_b), 0);
      chk("arst_no_donerx_a", 32'(drx_a - brx_a), 0);
      chk("arst_no_donerx_b", 32'(drx_b - brx_b), 0);

      qa.push_back(mk(9'hC3, 1'b0, 1'b0));
      send_chk(1'b0, 9'hC3, {7'd0, 1'b1, 8'hC3, 1'b0}, 10, 319);
      wait_rx(1'b0, 400);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
